// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, register-field
// positions and the fetch FSM state encoding.
package rv_defs;

    // addi x0, x0, 0 -- decodes to rs1 = rs2 = 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef logic [1:0] fetch_state_t;

    // REQ : may issue a request at pc
    // WAIT: one request outstanding, response still to come
    // KILL: outstanding response belongs to a squashed path
    // HOLD: response captured while decode was stalled
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// Request: a transfer happens on a rising edge where imem_req_valid and
// imem_req_ready are both high; imem_req_addr is meaningful only while valid
// is high. Response: imem_rsp_valid is a one-cycle strobe with
// imem_rsp_data, no backpressure, at least one cycle after acceptance.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush, stall (hold), load, bubble.
// Flush and bubble both write a NOP so the register fields read as x0.
module if_id_reg
    import rv_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    // Register update with flush > stall > load > bubble priority
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_instr <= NOP;
        end else if (i_stall) begin
            r_valid <= r_valid;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_instr <= NOP;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_rs1   = r_instr[RS1_LSB +: 5];
    assign o_rs2   = r_instr[RS2_LSB +: 5];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake,
// one-entry hold buffer for responses arriving during a decode stall, and
// the IF/ID register.
module fetch_stage
    import rv_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    fetch_stage_if.master     imem,
    output logic              if_id_valid,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic [4:0]        if_id_rs1,
    output logic [4:0]        if_id_rs2,
    output fetch_state_t      dbg_state
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;

    logic         w_req_valid;
    logic         w_handshake;
    logic         w_deliver;
    logic [31:0]  w_deliver_pc;
    logic [31:0]  w_deliver_instr;
    logic [31:0]  w_redirect_pc;
    logic         w_capture;

    // A redirect masks the request so it can never coincide with a handshake
    assign w_req_valid   = rst_n && (r_state == ST_REQ) && !stall_if && !redirect_valid;
    assign w_handshake   = w_req_valid && imem.imem_req_ready;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_capture     = (r_state == ST_WAIT) && imem.imem_rsp_valid &&
                           !redirect_valid && stall_id;

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_pc;
    assign dbg_state           = r_state;

    // Select what, if anything, is handed to IF/ID this cycle
    always_comb begin
        w_deliver       = 1'b0;
        w_deliver_pc    = r_hold_pc;
        w_deliver_instr = r_hold_instr;
        case (r_state)
            ST_WAIT: begin
                if (imem.imem_rsp_valid && !redirect_valid && !stall_id) begin
                    w_deliver       = 1'b1;
                    w_deliver_pc    = r_req_pc;
                    w_deliver_instr = imem.imem_rsp_data;
                end
            end
            ST_HOLD: begin
                if (!redirect_valid && !stall_id) begin
                    w_deliver = 1'b1;
                end
            end
            default: begin
                w_deliver = 1'b0;
            end
        endcase
    end

    // PC and outstanding-request address; the latest redirect always wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= 32'h0;
        end else begin
            if (w_handshake) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_handshake) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // Fetch FSM: one request in flight, squashed responses drained in KILL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_REQ;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_handshake) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (redirect_valid)  r_state <= ST_REQ;
                        else if (stall_id)   r_state <= ST_HOLD;
                        else                 r_state <= ST_REQ;
                    end else if (redirect_valid) begin
                        r_state <= ST_KILL;
                    end
                end
                ST_KILL: begin
                    if (imem.imem_rsp_valid) r_state <= ST_REQ;
                end
                ST_HOLD: begin
                    if (redirect_valid || !stall_id) r_state <= ST_REQ;
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

    // Hold buffer: park a response that arrives while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_instr <= NOP;
            r_hold_pc    <= 32'h0;
        end else if (w_capture) begin
            r_hold_instr <= imem.imem_rsp_data;
            r_hold_pc    <= r_req_pc;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_stall (stall_id),
        .i_load  (w_deliver),
        .i_pc    (w_deliver_pc),
        .i_instr (w_deliver_instr),
        .o_valid (if_id_valid),
        .o_pc    (if_id_pc),
        .o_instr (if_id_instr),
        .o_rs1   (if_id_rs1),
        .o_rs2   (if_id_rs2)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder with configurable latency and
// backpressure, a transaction-level model of the fetch stage, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fetch_stage;
    import rv_defs::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall_if;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic [1:0]  dbg_state;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents as a function of address
    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_8133;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // ---------------- memory responder state ----------------
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_low = 0;
    bit          rand_ready = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    // ---------------- fetch model (transaction level) ----------------
    logic [31:0] m_pc = 32'h0;
    bit          m_pend = 1'b0;
    bit          m_dead = 1'b0;
    logic [31:0] m_out_addr = 32'h0;
    bit          m_held = 1'b0;
    logic [31:0] m_held_pc = 32'h0;
    logic [31:0] m_held_instr = 32'h0;
    bit          m_valid = 1'b0;
    logic [31:0] m_ifid_pc = 32'h0;
    logic [31:0] m_ifid_instr = NOP;

    task automatic drive_mem();
        if (ready_low > 0)   bus.imem_req_ready = 1'b0;
        else if (rand_ready) bus.imem_req_ready = ($urandom_range(0, 3) != 0);
        else                 bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
        bus.imem_rsp_data  = (mem_busy && (mem_cnt == 0)) ? memdata(mem_addr) : $urandom;
    endtask

    task automatic model_update(input bit hs, input bit rsp);
        bit          deliver;
        logic [31:0] dpc;
        logic [31:0] dinstr;
        deliver = 1'b0;
        dpc     = 32'h0;
        dinstr  = NOP;
        if (!rst_n) begin
            m_pc = 32'h0; m_pend = 1'b0; m_dead = 1'b0; m_held = 1'b0;
            m_valid = 1'b0; m_ifid_pc = 32'h0; m_ifid_instr = NOP;
            return;
        end
        if (m_pend && rsp) begin
            m_pend = 1'b0;
            if (!(m_dead || redirect_valid)) begin
                if (stall_id) begin
                    m_held = 1'b1; m_held_pc = m_out_addr; m_held_instr = memdata(m_out_addr);
                end else begin
                    deliver = 1'b1; dpc = m_out_addr; dinstr = memdata(m_out_addr);
                end
            end
        end else if (m_held) begin
            if (redirect_valid) begin
                m_held = 1'b0;
            end else if (!stall_id) begin
                m_held = 1'b0; deliver = 1'b1; dpc = m_held_pc; dinstr = m_held_instr;
            end
        end
        if (m_pend && redirect_valid) m_dead = 1'b1;
        if (hs) begin
            m_pend = 1'b1; m_dead = 1'b0; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
        end
        if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (redirect_valid) begin
            m_valid = 1'b0; m_ifid_pc = 32'h0; m_ifid_instr = NOP;
        end else if (stall_id) begin
            m_valid = m_valid;
        end else if (deliver) begin
            m_valid = 1'b1; m_ifid_pc = dpc; m_ifid_instr = dinstr;
        end else begin
            m_valid = 1'b0; m_ifid_pc = 32'h0; m_ifid_instr = NOP;
        end
    endtask

    // One clock cycle: inputs already set; compare at negedge, advance at posedge
    task automatic step();
        bit          exp_rv;
        bit          mem_hs;
        bit          m_hs;
        bit          rsp;
        logic [31:0] hs_addr;
        drive_mem();
        @(negedge clk);
        exp_rv = rst_n && !m_pend && !m_held && !stall_if && !redirect_valid;
        if (chk_en) begin
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
            if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
            chk("ifid_valid", 32'(if_id_valid), 32'(m_valid));
            chk("ifid_pc", if_id_pc, m_ifid_pc);
            chk("ifid_instr", if_id_instr, m_ifid_instr);
            chk("ifid_rs1", 32'(if_id_rs1), 32'(m_ifid_instr[19:15]));
            chk("ifid_rs2", 32'(if_id_rs2), 32'(m_ifid_instr[24:20]));
        end
        mem_hs  = bus.imem_req_valid && bus.imem_req_ready;
        m_hs    = exp_rv && bus.imem_req_ready;
        hs_addr = bus.imem_req_addr;
        rsp     = bus.imem_rsp_valid;
        @(posedge clk);
        if (!rst_n) begin
            mem_busy = 1'b0;
        end else begin
            if (mem_busy) begin
                if (mem_cnt == 0) mem_busy = 1'b0;
                else              mem_cnt--;
            end
            if (mem_hs) begin
                mem_busy = 1'b1;
                mem_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
                mem_addr = hs_addr;
            end
        end
        if (ready_low > 0) ready_low--;
        model_update(m_hs, rsp);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit found;
        rst_n = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        chk("rst_ifid_valid", 32'(if_id_valid), 32'h0);
        chk("rst_ifid_instr", if_id_instr, 32'h0000_0013);
        chk("rst_ifid_rs1", 32'(if_id_rs1), 32'h0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_REQ));

        // First fetch after reset with a 1-cycle memory
        rst_n = 1'b1; #1;
        chk("s1_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("s1_req_addr", bus.imem_req_addr, 32'h0);
        step(); #1;
        chk("s1_wait_no_req", 32'(bus.imem_req_valid), 32'h0);
        step(); #1;
        chk("s1_ifid_valid", 32'(if_id_valid), 32'h1);
        chk("s1_ifid_pc", if_id_pc, 32'h0);
        chk("s1_ifid_rs1", 32'(if_id_rs1), 32'd1);
        chk("s1_ifid_rs2", 32'(if_id_rs2), 32'd2);
        chk("s1_next_addr", bus.imem_req_addr, 32'h4);

        // Response arriving under a 3-cycle stall lands in the hold buffer
        step();
        stall_if = 1'b1; stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("s2_stall_hold", 32'(if_id_valid), 32'h0);
        end
        stall_if = 1'b0; stall_id = 1'b0;
        lat_min = 4; lat_max = 4;
        step(); #1;
        chk("s2_release_valid", 32'(if_id_valid), 32'h1);
        chk("s2_release_pc", if_id_pc, 32'h4);
        chk("s2_release_instr", if_id_instr, memdata(32'h4));
        step(); #1;
        chk("s2_no_dup", 32'(if_id_valid), 32'h0);

        // Redirect during WAIT, response three cycles later is dropped
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            chk("s3_ifid_flushed", 32'(if_id_valid), 32'h0);
            if (bus.imem_req_valid) found = 1'b1;
            else step();
        end
        chk("s3_refetch_seen", 32'(found), 32'h1);
        chk("s3_refetch_addr", bus.imem_req_addr, 32'h0000_0100);

        // Redirect together with a response while decode is stalled
        lat_min = 1; lat_max = 1;
        step();
        redirect_valid = 1'b1; stall_id = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0; stall_id = 1'b0; #1;
        chk("s4_ifid_valid", 32'(if_id_valid), 32'h0);
        chk("s4_ifid_instr", if_id_instr, 32'h0000_0013);
        chk("s4_ifid_rs1", 32'(if_id_rs1), 32'h0);
        chk("s4_ifid_rs2", 32'(if_id_rs2), 32'h0);
        chk("s4_target", bus.imem_req_addr, 32'h0000_0200);

        // Backpressure: request stays asserted and stable
        ready_low = 4;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("s5_bp_valid", 32'(bus.imem_req_valid), 32'h1);
            chk("s5_bp_addr", bus.imem_req_addr, 32'h0000_0200);
        end
        step();
        step(); #1;
        chk("s5_pc_plus4", bus.imem_req_addr, 32'h0000_0204);

        // Top-of-memory fetch wraps the PC
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0; #1;
        chk("s6_aligned", bus.imem_req_addr, 32'hFFFF_FFFC);
        step();
        step(); #1;
        chk("s6_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("s6_wrap_addr", bus.imem_req_addr, 32'h0);

        // Randomized traffic
        rand_ready = 1'b1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            stall_if       = ($urandom_range(0, 3) == 0);
            stall_id       = ($urandom_range(0, 4) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
